// File: rtl/mig_cmd_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : mig_cmd_sched_if
//  Purpose  : Bundles the request-queue, write-data-buffer, MIG app command,
//             MIG write-data, MIG read-return and status signals of the
//             command scheduler.
//  Modports : master - scheduler side (drives pops, MIG app outputs, status)
//             slave  - environment side (queue, wd buffer, MIG core)
//  Revision : 1.0 - initial release
// ============================================================================
interface mig_cmd_sched_if #(
  parameter int APPAW = 28,
  parameter int DW    = 128
);
  // Request queue
  logic                init_calib_complete;
  logic                rqempty;
  logic [31:0]         qraddr;
  logic                rd_bwt;
  logic                rnext;
  // Write-data buffer
  logic                wd_valid;
  logic [DW-1:0]       wd_data;
  logic [DW/8-1:0]     wd_mask;
  logic                wd_next;
  // MIG command
  logic                app_en;
  logic [2:0]          app_cmd;
  logic [APPAW-1:0]    app_addr;
  logic                app_rdy;
  // MIG write data
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DW-1:0]       app_wdf_data;
  logic [DW/8-1:0]     app_wdf_mask;
  logic                app_wdf_rdy;
  // MIG read return and requester-side copy
  logic [DW-1:0]       app_rd_data;
  logic                app_rd_data_valid;
  logic [DW-1:0]       rd_data;
  logic                rd_valid;
  // Status
  logic                busy;
  logic                sched_err;

  modport master (
    input  init_calib_complete, rqempty, qraddr, rd_bwt,
    input  wd_valid, wd_data, wd_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output rnext, wd_next,
    output app_en, app_cmd, app_addr,
    output app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
    output rd_data, rd_valid, busy, sched_err
  );

  modport slave (
    output init_calib_complete, rqempty, qraddr, rd_bwt,
    output wd_valid, wd_data, wd_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  rnext, wd_next,
    input  app_en, app_cmd, app_addr,
    input  app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
    input  rd_data, rd_valid, busy, sched_err
  );
endinterface
`default_nettype wire

// File: rtl/mig_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mig_cmd_sched
//  Purpose  : Pops one request at a time from the queue head and issues it to
//             the MIG app interface as a single BL8 command. Writes first
//             send one write-data beat, then the command. Reads are limited
//             to RD_OUTST in flight; read return data is registered back.
//  Ports    : clk    - sole clock
//             rst_n  - asynchronous active-low reset
//             bus    - mig_cmd_sched_if.master (queue, wd buffer, MIG app,
//                      read return, busy, sched_err)
//  Options  : MIG_SCHED_WDOG_EN - enables the stall watchdog driving
//             sched_err; when undefined sched_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module mig_cmd_sched #(
  parameter int APPAW    = 28,
  parameter int DW       = 128,
  parameter int RD_OUTST = 4,
  parameter int WDOG_LIM = 1023
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  mig_cmd_sched_if.master bus
);
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RCMD  = 2'd1,
    S_WDATA = 2'd2,
    S_WCMD  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_outst;
  logic              w_can_pop;
  logic              w_start_rd;
  logic              w_start_wr;
  logic              w_rnext;
  logic              w_wd_next;
  logic              w_outst_inc;
  logic              w_outst_dec;
  logic [APPAW-1:0]  w_cmd_addr;

  logic              r_app_en;
  logic [2:0]        r_app_cmd;
  logic [APPAW-1:0]  r_app_addr;
  logic              r_wdf_wren;
  logic [DW-1:0]     r_wdf_data;
  logic [MW-1:0]     r_wdf_mask;
  logic              r_rd_valid;
  logic [DW-1:0]     r_rd_data;

  // BL8 alignment: address bits above APPAW dropped, low three bits cleared.
  assign w_cmd_addr = {bus.qraddr[APPAW-1:3], 3'b000};

  // rst_n is included so the combinational pop pulse stays low during reset.
  assign w_can_pop  = rst_n && (r_state == S_IDLE) && bus.init_calib_complete && !bus.rqempty;
  assign w_start_rd = w_can_pop &&  bus.rd_bwt && (r_outst < 4'(RD_OUTST));
  assign w_start_wr = w_can_pop && !bus.rd_bwt && bus.wd_valid;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rnext     = 1'b0;
    w_wd_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_rd) begin
          w_rnext     = 1'b1;
          w_state_nxt = S_RCMD;
        end else if (w_start_wr) begin
          w_rnext     = 1'b1;
          w_state_nxt = S_WDATA;
        end
      end
      S_RCMD: begin
        if (bus.app_rdy) w_state_nxt = S_IDLE;
      end
      S_WDATA: begin
        if (bus.app_wdf_rdy) begin
          w_wd_next   = 1'b1;
          w_state_nxt = S_WCMD;
        end
      end
      S_WCMD: begin
        if (bus.app_rdy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.rnext   = w_rnext;
  assign bus.wd_next = w_wd_next;

  // ------------------------------------------------- registered MIG outputs
  // Strobes follow the next state so they rise one cycle after the pop and
  // fall the cycle after acceptance. Command/address/data are captured at
  // pop and held constant for the whole command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_app_en   <= 1'b0;
      r_app_cmd  <= 3'b000;
      r_app_addr <= '0;
      r_wdf_wren <= 1'b0;
      r_wdf_data <= '0;
      r_wdf_mask <= '0;
    end else begin
      r_app_en   <= (w_state_nxt == S_RCMD) || (w_state_nxt == S_WCMD);
      r_wdf_wren <= (w_state_nxt == S_WDATA);
      if (w_start_rd) begin
        r_app_cmd  <= 3'b001;
        r_app_addr <= w_cmd_addr;
      end else if (w_start_wr) begin
        r_app_cmd  <= 3'b000;
        r_app_addr <= w_cmd_addr;
        r_wdf_data <= bus.wd_data;
        r_wdf_mask <= bus.wd_mask;
      end
    end
  end

  assign bus.app_en       = r_app_en;
  assign bus.app_cmd      = r_app_cmd;
  assign bus.app_addr     = r_app_addr;
  assign bus.app_wdf_wren = r_wdf_wren;
  assign bus.app_wdf_end  = r_wdf_wren;
  assign bus.app_wdf_data = r_wdf_data;
  assign bus.app_wdf_mask = r_wdf_mask;

  // ------------------------------------------------ outstanding reads
  assign w_outst_inc = (r_state == S_RCMD) && bus.app_rdy && (r_outst < 4'(RD_OUTST));
  assign w_outst_dec = bus.app_rd_data_valid && (r_outst != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst <= 4'd0;
    end else begin
      case ({w_outst_inc, w_outst_dec})
        2'b10:   r_outst <= r_outst + 4'd1;
        2'b01:   r_outst <= r_outst - 4'd1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  // ------------------------------------------------ read return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.app_rd_data_valid;
      if (bus.app_rd_data_valid) r_rd_data <= bus.app_rd_data;
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.busy     = (r_state != S_IDLE) || (r_outst != 4'd0);

  // ------------------------------------------------ stall watchdog
`ifdef MIG_SCHED_WDOG_EN
  localparam int WCW = $clog2(WDOG_LIM + 1);
  logic [WCW-1:0] r_wdog_cnt;
  logic           r_sched_err;
  logic           w_stall;

  assign w_stall = (((r_state == S_RCMD) || (r_state == S_WCMD)) && !bus.app_rdy) ||
                   ((r_state == S_WDATA) && !bus.app_wdf_rdy);

  // The error latches on the WDOG_LIM-th consecutive stall cycle; the FSM
  // itself keeps waiting for the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt  <= '0;
      r_sched_err <= 1'b0;
    end else begin
      if (!w_stall)                                r_wdog_cnt <= '0;
      else if (r_wdog_cnt != WCW'(WDOG_LIM))       r_wdog_cnt <= r_wdog_cnt + WCW'(1);
      if (w_stall && (r_wdog_cnt == WCW'(WDOG_LIM - 1))) r_sched_err <= 1'b1;
    end
  end

  assign bus.sched_err = r_sched_err;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = ^WDOG_LIM;
  assign bus.sched_err = 1'b0;
`endif

  // Address bits outside the MIG address range are intentionally unused.
  logic w_unused_addr;
  assign w_unused_addr = ^{bus.qraddr[31:APPAW], bus.qraddr[2:0]};

endmodule
`default_nettype wire

// File: tb/tb_mig_cmd_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mig_cmd_sched
//  Purpose  : Self-checking bench for mig_cmd_sched: table of single
//             read/write transactions plus directed multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mig_cmd_sched;
  localparam int APPAW = 28;
  localparam int DW    = 128;
  localparam int MW    = 16;
`ifdef MIG_SCHED_WDOG_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mig_cmd_sched_if #(.APPAW(APPAW), .DW(DW)) bus ();

  mig_cmd_sched #(.APPAW(APPAW), .DW(DW), .RD_OUTST(4), .WDOG_LIM(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Request queue model
  logic [31:0] q_addr [0:63];
  logic        q_rd   [0:63];
  int qhead = 0;
  int qtail = 0;
  assign bus.rqempty = (qhead == qtail);
  assign bus.qraddr  = q_addr[qhead[5:0]];
  assign bus.rd_bwt  = q_rd[qhead[5:0]];

  int n_rnext = 0, n_wdnext = 0, n_racc = 0, n_wacc = 0, n_en = 0;
  always @(posedge clk) begin
    if (bus.rnext) begin
      qhead   <= qhead + 1;
      n_rnext <= n_rnext + 1;
    end
    if (bus.wd_next) n_wdnext <= n_wdnext + 1;
    if (bus.app_en) n_en <= n_en + 1;
    if (bus.app_en && bus.app_rdy && bus.app_cmd == 3'b001) n_racc <= n_racc + 1;
    if (bus.app_en && bus.app_rdy && bus.app_cmd == 3'b000) n_wacc <= n_wacc + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic rd, input logic [31:0] a);
    q_addr[qtail[5:0]] = a;
    q_rd[qtail[5:0]]   = rd;
    qtail++;
  endtask

  task automatic rd_return(input logic [127:0] d);
    bus.app_rd_data       = d;
    bus.app_rd_data_valid = 1'b1;
    tick();
    bus.app_rd_data_valid = 1'b0;
  endtask

  typedef struct {
    logic         rd;
    logic [31:0]  qa;
    logic [127:0] dat;
    logic [15:0]  msk;
    logic [2:0]   ecmd;
    logic [27:0]  eaddr;
  } vec_t;
  vec_t vt [0:4];

  initial begin
    int base, base2;
    bit ok, sw, rn_seen;
    logic [127:0] cd;
    logic [15:0]  cm;

    vt[0] = '{1'b1, 32'h0000_1237, 128'hA1A1_0000_0000_0000_0000_0000_0000_0001, 16'h0000, 3'b001, 28'h000_1230};
    vt[1] = '{1'b0, 32'h0000_2008, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA, 16'h00FF, 3'b000, 28'h000_2008};
    vt[2] = '{1'b1, 32'hFFFF_FFFF, 128'h0F0F_F0F0_1111_2222_3333_4444_5555_6666, 16'h0000, 3'b001, 28'hFFF_FFF8};
    vt[3] = '{1'b0, 32'hABCD_EF07, 128'h1234_0000_FFFF_0000_CAFE_F00D_0000_7777, 16'hA5C3, 3'b000, 28'hBCD_EF00};
    vt[4] = '{1'b1, 32'h1234_567F, 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE, 16'h0000, 3'b001, 28'h234_5678};

    bus.init_calib_complete = 1'b1;
    bus.wd_valid = 1'b0;  bus.wd_data = '0;  bus.wd_mask = '0;
    bus.app_rdy = 1'b1;   bus.app_wdf_rdy = 1'b1;
    bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0;

    // ---- reset with a read waiting at the head
    push(1'b1, 32'h0000_1237);
    rn_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.rnext) rn_seen = 1;
    end
    chk("rst_rnext", rn_seen, 1'b0);
    chk("rst_app_en", bus.app_en, 1'b0);
    chk("rst_app_cmd", bus.app_cmd, 3'b000);
    chk("rst_app_addr", bus.app_addr, 28'h0);
    chk("rst_wren", bus.app_wdf_wren, 1'b0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_rd_data", bus.rd_data, 128'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.sched_err, 1'b0);
    rst_n = 1'b1;
    #1 chk("rel_rnext_c1", bus.rnext, 1'b1);
    tick();
    chk("rel_en_c2", bus.app_en, 1'b1);
    chk("rel_cmd_c2", bus.app_cmd, 3'b001);
    chk("rel_addr_c2", bus.app_addr, 28'h000_1230);
    chk("rel_rnext_c2", bus.rnext, 1'b0);
    tick();
    chk("rel_en_c3", bus.app_en, 1'b0);
    chk("rel_busy_outst", bus.busy, 1'b1);
    rd_return(128'h55);
    chk("rel_rd_valid", bus.rd_valid, 1'b1);
    chk("rel_rd_data", bus.rd_data, 128'h55);
    tick();
    chk("rel_busy_idle", bus.busy, 1'b0);

    // ---- table of single transactions
    for (int k = 0; k < 5; k++) begin
      if (!vt[k].rd) begin
        bus.wd_valid = 1'b1;
        bus.wd_data  = vt[k].dat;
        bus.wd_mask  = vt[k].msk;
      end
      push(vt[k].rd, vt[k].qa);
      ok = 0; sw = 0; cd = '0; cm = '0;
      for (int i = 0; i < 30 && !ok; i++) begin
        tick();
        bus.wd_data = ~vt[k].dat;   // must not affect data captured at pop
        bus.wd_mask = ~vt[k].msk;
        if (bus.app_wdf_wren) begin
          sw = 1; cd = bus.app_wdf_data; cm = bus.app_wdf_mask;
        end
        if (bus.app_en) ok = 1;
      end
      chk($sformatf("v%0d_app_en", k), ok, 1'b1);
      chk($sformatf("v%0d_cmd", k), bus.app_cmd, vt[k].ecmd);
      chk($sformatf("v%0d_addr", k), bus.app_addr, vt[k].eaddr);
      if (!vt[k].rd) begin
        chk($sformatf("v%0d_wren", k), sw, 1'b1);
        chk($sformatf("v%0d_wdata", k), cd, vt[k].dat);
        chk($sformatf("v%0d_wmask", k), cm, vt[k].msk);
        bus.wd_valid = 1'b0;
      end
      tick();
      chk($sformatf("v%0d_en_drop", k), bus.app_en, 1'b0);
      if (vt[k].rd) begin
        rd_return(vt[k].dat);
        chk($sformatf("v%0d_rd_valid", k), bus.rd_valid, 1'b1);
        chk($sformatf("v%0d_rd_data", k), bus.rd_data, vt[k].dat);
      end
      tick();
      chk($sformatf("v%0d_busy", k), bus.busy, 1'b0);
    end

    // ---- outstanding limit: 6 reads, no return
    base = n_rnext;
    for (int i = 0; i < 6; i++) push(1'b1, 32'h100 + 32'(i * 8));
    tick(20);
    chk("lim_pops4", n_rnext - base, 4);
    chk("lim_busy", bus.busy, 1'b1);
    rd_return(128'h1);
    tick(10);
    chk("lim_pops5", n_rnext - base, 5);
    for (int i = 0; i < 5; i++) begin
      rd_return(128'h2 + 128'(i));
      tick(4);
    end
    tick(5);
    chk("lim_pops6", n_rnext - base, 6);
    chk("lim_drained", bus.busy, 1'b0);
    rd_return(128'hBAD);   // spurious return with nothing outstanding
    tick();
    chk("spurious_busy", bus.busy, 1'b0);

    // ---- write with app_wdf_rdy low for 5 cycles
    bus.app_wdf_rdy = 1'b0;
    bus.wd_valid = 1'b1;
    bus.wd_data  = 128'hFEED;
    bus.wd_mask  = 16'h0F0F;
    base = n_wdnext;
    push(1'b0, 32'h0000_4000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("wst_wren_c%0d", i + 1), bus.app_wdf_wren, 1'b1);
      chk($sformatf("wst_wdnext_c%0d", i + 1), bus.wd_next, 1'b0);
    end
    tick();
    bus.app_wdf_rdy = 1'b1;
    #1 chk("wst_wren_c6", bus.app_wdf_wren, 1'b1);
    chk("wst_wdnext_c6", bus.wd_next, 1'b1);
    chk("wst_wend_c6", bus.app_wdf_end, 1'b1);
    bus.wd_valid = 1'b0;
    tick();
    chk("wst_wren_drop", bus.app_wdf_wren, 1'b0);
    chk("wst_app_en", bus.app_en, 1'b1);
    chk("wst_cmd", bus.app_cmd, 3'b000);
    chk("wst_addr", bus.app_addr, 28'h000_4000);
    tick();
    chk("wst_en_drop", bus.app_en, 1'b0);
    chk("wst_wdnext_once", n_wdnext - base, 1);

    // ---- write head with no write data: not popped
    base = n_rnext; base2 = n_wacc;
    push(1'b0, 32'h0000_5000);
    tick(6);
    chk("nowd_no_pop", n_rnext - base, 0);
    chk("nowd_no_en", bus.app_en, 1'b0);
    bus.wd_valid = 1'b1;
    tick(6);
    bus.wd_valid = 1'b0;
    chk("nowd_then_write", n_wacc - base2, 1);

    // ---- outst=2 with RCMD accept coincident with a read return
    base = n_racc;
    push(1'b1, 32'h600); push(1'b1, 32'h608);
    tick(6);
    chk("co_two_acc", n_racc - base, 2);
    bus.app_rdy = 1'b0;
    push(1'b1, 32'h610);
    tick(2);
    bus.app_rdy = 1'b1;
    rd_return(128'hC0DE_0001);
    bus.app_rd_data = 128'hBAD0;
    chk("co_rd_valid", bus.rd_valid, 1'b1);
    chk("co_rd_data", bus.rd_data, 128'hC0DE_0001);
    chk("co_acc3", n_racc - base, 3);
    tick();
    chk("co_rd_valid_drop", bus.rd_valid, 1'b0);
    chk("co_rd_data_hold", bus.rd_data, 128'hC0DE_0001);
    base = n_rnext;
    for (int i = 0; i < 4; i++) push(1'b1, 32'h700 + 32'(i * 8));
    tick(20);
    chk("co_outst2_pops", n_rnext - base, 2);
    for (int i = 0; i < 6; i++) begin
      rd_return(128'h10 + 128'(i));
      tick(4);
    end
    tick(4);
    chk("co_all_pops", n_rnext - base, 4);
    chk("co_drained", bus.busy, 1'b0);

    // ---- calibration gating
    bus.init_calib_complete = 1'b0;
    base = n_rnext; base2 = n_en;
    bus.app_rdy = 1'b0;
    push(1'b1, 32'h800);
    tick(20);
    chk("cal_no_pop", n_rnext - base, 0);
    chk("cal_no_en", n_en - base2, 0);
    bus.init_calib_complete = 1'b1;
    #1 chk("cal_pop_same", bus.rnext, 1'b1);
    base = n_racc;
    tick();
    bus.init_calib_complete = 1'b0;   // drop mid-command
    tick(3);
    chk("cal_drop_en_held", bus.app_en, 1'b1);
    bus.app_rdy = 1'b1;
    tick();
    chk("cal_drop_acc", n_racc - base, 1);
    chk("cal_drop_en_off", bus.app_en, 1'b0);
    bus.init_calib_complete = 1'b1;
    rd_return(128'h99);
    tick(2);
    chk("cal_busy", bus.busy, 1'b0);

    // ---- stall watchdog (expected to stay low without the option)
    bus.app_rdy = 1'b0;
    push(1'b1, 32'h900);
    tick();
    tick(15);
    chk("wd_err_15", bus.sched_err, 1'b0);
    tick();
    chk("wd_err_16", bus.sched_err, EXP_ERR);
    chk("wd_en_waiting", bus.app_en, 1'b1);
    bus.app_rdy = 1'b1;
    tick(2);
    chk("wd_err_sticky", bus.sched_err, EXP_ERR);
    chk("wd_busy_outst", bus.busy, 1'b1);

    // ---- reset mid-operation clears error and outstanding count
    rst_n = 1'b0;
    #1 chk("mrst_err", bus.sched_err, 1'b0);
    chk("mrst_busy", bus.busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick(2);
    chk("mrst_outst_clear", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
